// File: rtl/parc_mem_port_buffer_pkg.sv
// parc_mem_port_buffer_pkg
//   Shared definitions for the data-memory port buffer.
//   - Memory request message packing  : {type, addr, len, data}  (MSB..LSB)
//   - Memory response message packing : {type, len, data}        (MSB..LSB)
//   - Type encodings and a counter-width helper.
package parc_mem_port_buffer_pkg;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_type_e;

    localparam int MEM_TYPE_W = 1;
    localparam int MEM_LEN_W  = 2;

    // Request message: total width and field offsets (LSB of each field).
    function automatic int req_msg_w(input int addr_sz, input int data_sz);
        return MEM_TYPE_W + addr_sz + MEM_LEN_W + data_sz;
    endfunction

    function automatic int req_data_lsb();
        return 0;
    endfunction

    function automatic int req_len_lsb(input int data_sz);
        return data_sz;
    endfunction

    function automatic int req_addr_lsb(input int data_sz);
        return data_sz + MEM_LEN_W;
    endfunction

    function automatic int req_type_lsb(input int addr_sz, input int data_sz);
        return data_sz + MEM_LEN_W + addr_sz;
    endfunction

    // Response message: total width and field offsets.
    function automatic int resp_msg_w(input int data_sz);
        return MEM_TYPE_W + MEM_LEN_W + data_sz;
    endfunction

    function automatic int resp_len_lsb(input int data_sz);
        return data_sz;
    endfunction

    function automatic int resp_type_lsb(input int data_sz);
        return data_sz + MEM_LEN_W;
    endfunction

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/parc_mem_port_buffer_if.sv
// parc_mem_port_buffer_if
//   Bundles the core-side and memory-side handshakes of the port buffer.
//   slave  : the buffer's view (accepts core requests and memory responses).
//   master : the environment's view (core + memory system).
//   Signals: req_in_*  core -> buffer request     req_out_*  buffer -> memory request
//            resp_in_* memory -> buffer response  resp_out_* buffer -> core response
//            error     sticky protocol-error flag
interface parc_mem_port_buffer_if
    import parc_mem_port_buffer_pkg::*;
#(
    parameter int P_ADDR_SZ = 32,
    parameter int P_DATA_SZ = 32
);
    localparam int REQ_W  = req_msg_w(P_ADDR_SZ, P_DATA_SZ);
    localparam int RESP_W = resp_msg_w(P_DATA_SZ);

    logic [REQ_W-1:0]  req_in_msg;
    logic              req_in_val;
    logic              req_in_rdy;
    logic [REQ_W-1:0]  req_out_msg;
    logic              req_out_val;
    logic              req_out_rdy;
    logic [RESP_W-1:0] resp_in_msg;
    logic              resp_in_val;
    logic [RESP_W-1:0] resp_out_msg;
    logic              resp_out_val;
    logic              resp_out_rdy;
    logic              error;

    modport slave (
        input  req_in_msg, req_in_val, req_out_rdy,
        input  resp_in_msg, resp_in_val, resp_out_rdy,
        output req_in_rdy, req_out_msg, req_out_val,
        output resp_out_msg, resp_out_val, error
    );

    modport master (
        output req_in_msg, req_in_val, req_out_rdy,
        output resp_in_msg, resp_in_val, resp_out_rdy,
        input  req_in_rdy, req_out_msg, req_out_val,
        input  resp_out_msg, resp_out_val, error
    );

endinterface

// File: rtl/parc_mem_resp_fifo.sv
// parc_mem_resp_fifo
//   In-order response storage of P_DEPTH entries (any depth >= 1).
//   Ports: clk/reset, i_enq_val/i_enq_msg (no ready: caller decides what to
//   push), i_deq_rdy, o_deq_val/o_deq_msg (head entry), o_full, o_empty.
//   A push while full is accepted only if a pop happens the same cycle.
module parc_mem_resp_fifo
    import parc_mem_port_buffer_pkg::*;
#(
    parameter int P_DEPTH = 2,
    parameter int P_W     = 35
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_enq_val,
    input  logic [P_W-1:0] i_enq_msg,
    input  logic           i_deq_rdy,
    output logic           o_deq_val,
    output logic [P_W-1:0] o_deq_msg,
    output logic           o_full,
    output logic           o_empty
);
    localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int OW = cnt_w(P_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(P_DEPTH - 1);

    logic [P_W-1:0] r_mem [P_DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [OW-1:0]  r_occ;

    logic w_deq;
    logic w_enq;

    assign o_empty   = (r_occ == '0);
    assign o_full    = (r_occ == OW'(P_DEPTH));
    assign o_deq_val = ~o_empty;
    assign o_deq_msg = r_mem[r_head];

    assign w_deq = i_deq_rdy & ~o_empty;
    assign w_enq = i_enq_val & (~o_full | w_deq);

    // Explicit wrap so non-power-of-two depths work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_deq) r_head <= (r_head == LAST) ? '0 : r_head + PW'(1);
            if (w_enq) r_tail <= (r_tail == LAST) ? '0 : r_tail + PW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= i_enq_msg;
    end

endmodule

// File: rtl/parc_mem_port_buffer.sv
// parc_mem_port_buffer
//   Credit-gated request pass-through plus a p_depth-entry response FIFO
//   between the core data-memory port and the memory system.
//   Ports: clk, reset (async, active-high), port (parc_mem_port_buffer_if.slave)
//   carrying req_in/req_out/resp_in/resp_out handshakes and the sticky error.
//   Optional: define PARC_MEM_PORT_BUFFER_BYPASS_EN to let a response pass
//   straight to the core in the arrival cycle when the FIFO is empty.
module parc_mem_port_buffer
    import parc_mem_port_buffer_pkg::*;
#(
    parameter int p_addr_sz = 32,
    parameter int p_data_sz = 32,
    parameter int p_depth   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    parc_mem_port_buffer_if.slave   port
);
    localparam int CW     = cnt_w(p_depth);
    localparam int RESP_W = resp_msg_w(p_data_sz);

    logic [CW-1:0]     r_cnt;
    logic              r_err;

    logic              w_credit;
    logic              w_req_fire;
    logic              w_resp_out_fire;
    logic              w_spurious;
    logic              w_overflow;
    logic              w_fifo_deq;
    logic              w_enq;
    logic              w_byp;
    logic              w_byp_take;
    logic              w_full;
    logic              w_empty;
    logic              w_head_val;
    logic [RESP_W-1:0] w_head_msg;

    // Registered count only: a same-cycle dequeue must not return credit,
    // keeping resp_out_rdy off the req_in_rdy path.
    assign w_credit        = (r_cnt < CW'(p_depth));
    assign port.req_out_msg = port.req_in_msg;
    assign port.req_out_val = port.req_in_val & w_credit;
    assign port.req_in_rdy  = port.req_out_rdy & w_credit;
    assign w_req_fire       = port.req_in_val & port.req_in_rdy;

    assign w_spurious = port.resp_in_val & (r_cnt == '0);
    assign w_fifo_deq = port.resp_out_rdy & ~w_empty;
    assign w_overflow = port.resp_in_val & ~w_spurious & w_full & ~w_fifo_deq;

`ifdef PARC_MEM_PORT_BUFFER_BYPASS_EN
    assign w_byp      = port.resp_in_val & ~w_spurious & w_empty;
    assign w_byp_take = w_byp & port.resp_out_rdy;
`else
    assign w_byp      = 1'b0;
    assign w_byp_take = 1'b0;
`endif

    // Overflow drops are handled inside the FIFO (push refused when full).
    assign w_enq = port.resp_in_val & ~w_spurious & ~w_byp_take;

    assign port.resp_out_val = w_head_val | w_byp;
    assign port.resp_out_msg = w_byp ? port.resp_in_msg : w_head_msg;
    assign w_resp_out_fire   = port.resp_out_val & port.resp_out_rdy;
    assign port.error        = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case ({w_req_fire, w_resp_out_fire})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                // Guard against a misbehaving memory pushing extra responses.
                2'b01:   r_cnt <= (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
                default: r_cnt <= r_cnt;
            endcase
            if (w_spurious | w_overflow) r_err <= 1'b1;
        end
    end

    parc_mem_resp_fifo #(
        .P_DEPTH (p_depth),
        .P_W     (RESP_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_enq_val (w_enq),
        .i_enq_msg (port.resp_in_msg),
        .i_deq_rdy (port.resp_out_rdy),
        .o_deq_val (w_head_val),
        .o_deq_msg (w_head_msg),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_parc_mem_port_buffer.sv
// tb_parc_mem_port_buffer
//   Directed bench: a depth-2 instance for the main scenarios and a depth-3
//   instance for the full-FIFO / pointer-wrap scenario.
module tb_parc_mem_port_buffer;
    import parc_mem_port_buffer_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    parc_mem_port_buffer_if #(.P_ADDR_SZ(32), .P_DATA_SZ(32)) m2 ();
    parc_mem_port_buffer_if #(.P_ADDR_SZ(32), .P_DATA_SZ(32)) m3 ();

    parc_mem_port_buffer #(.p_addr_sz(32), .p_data_sz(32), .p_depth(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .port  (m2.slave)
    );

    parc_mem_port_buffer #(.p_addr_sz(32), .p_data_sz(32), .p_depth(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .port  (m3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [66:0] rq(input logic t, input logic [31:0] a, input logic [31:0] d);
        return {t, a, 2'd0, d};
    endfunction

    function automatic logic [34:0] rs(input logic t, input logic [31:0] d);
        return {t, 2'd0, d};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        m2.req_in_msg = '0; m2.req_in_val = 1'b0; m2.req_out_rdy = 1'b0;
        m2.resp_in_msg = '0; m2.resp_in_val = 1'b0; m2.resp_out_rdy = 1'b0;
        m3.req_in_msg = '0; m3.req_in_val = 1'b0; m3.req_out_rdy = 1'b0;
        m3.resp_in_msg = '0; m3.resp_in_val = 1'b0; m3.resp_out_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m2.req_out_rdy = 1'b1;
        #1;
        chk("reset_req_in_rdy", 80'(m2.req_in_rdy), 80'd1);
        chk("reset_resp_out_val", 80'(m2.resp_out_val), 80'd0);
        chk("reset_error", 80'(m2.error), 80'd0);

        // Single read to 0x100, response 0xDEADBEEF three cycles later.
        m2.req_in_msg = rq(MEM_RD, 32'h100, 32'd0);
        m2.req_in_val = 1'b1;
        #1;
        chk("rd_req_out_val", 80'(m2.req_out_val), 80'd1);
        chk("rd_req_out_msg", 80'(m2.req_out_msg), 80'(rq(MEM_RD, 32'h100, 32'd0)));
        tick();
        m2.req_in_val = 1'b0;
        chk("rd_cnt_after_issue", 80'(dut2.r_cnt), 80'd1);
        tick();
        tick();
        m2.resp_in_msg  = rs(MEM_RD, 32'hDEADBEEF);
        m2.resp_in_val  = 1'b1;
        m2.resp_out_rdy = 1'b1;
        #1;
`ifdef PARC_MEM_PORT_BUFFER_BYPASS_EN
        chk("rd_bypass_val", 80'(m2.resp_out_val), 80'd1);
        chk("rd_bypass_msg", 80'(m2.resp_out_msg), 80'(rs(MEM_RD, 32'hDEADBEEF)));
        tick();
        m2.resp_in_val = 1'b0;
        #1;
`else
        chk("rd_val_same_cycle", 80'(m2.resp_out_val), 80'd0);
        tick();
        m2.resp_in_val = 1'b0;
        #1;
        chk("rd_val_next_cycle", 80'(m2.resp_out_val), 80'd1);
        chk("rd_msg", 80'(m2.resp_out_msg), 80'(rs(MEM_RD, 32'hDEADBEEF)));
        tick();
`endif
        chk("rd_val_drained", 80'(m2.resp_out_val), 80'd0);
        chk("rd_cnt_zero", 80'(dut2.r_cnt), 80'd0);

        // Credit exhaustion: three back-to-back requests, memory silent.
        m2.resp_out_rdy = 1'b0;
        m2.req_in_msg   = rq(MEM_WR, 32'h200, 32'h1234);
        m2.req_in_val   = 1'b1;
        #1;
        chk("cr_rdy_first", 80'(m2.req_in_rdy), 80'd1);
        tick();
        chk("cr_rdy_second", 80'(m2.req_in_rdy), 80'd1);
        tick();
        chk("cr_rdy_third_blocked", 80'(m2.req_in_rdy), 80'd0);
        chk("cr_req_out_val_blocked", 80'(m2.req_out_val), 80'd0);
        tick();
        chk("cr_still_blocked", 80'(m2.req_in_rdy), 80'd0);
        m2.resp_in_msg = rs(MEM_WR, 32'hAA);
        m2.resp_in_val = 1'b1;
        tick();
        m2.resp_in_val  = 1'b0;
        m2.resp_out_rdy = 1'b1;
        #1;
        chk("cr_no_same_cycle_credit", 80'(m2.req_in_rdy), 80'd0);
        chk("cr_resp_val", 80'(m2.resp_out_val), 80'd1);
        tick();
        m2.resp_out_rdy = 1'b0;
        #1;
        chk("cr_credit_next_cycle", 80'(m2.req_in_rdy), 80'd1);
        tick();
        m2.req_in_val = 1'b0;
        chk("cr_cnt_two", 80'(dut2.r_cnt), 80'd2);

        // Core stall: two responses held, then released in order.
        m2.resp_in_msg = rs(MEM_RD, 32'h11);
        m2.resp_in_val = 1'b1;
        tick();
        m2.resp_in_msg = rs(MEM_RD, 32'h22);
        tick();
        m2.resp_in_val = 1'b0;
        #1;
        chk("st_val_held", 80'(m2.resp_out_val), 80'd1);
        chk("st_error_clear", 80'(m2.error), 80'd0);
        chk("st_head_11", 80'(m2.resp_out_msg), 80'(rs(MEM_RD, 32'h11)));
        m2.resp_out_rdy = 1'b1;
        tick();
        chk("st_second_val", 80'(m2.resp_out_val), 80'd1);
        chk("st_head_22", 80'(m2.resp_out_msg), 80'(rs(MEM_RD, 32'h22)));
        tick();
        chk("st_drained", 80'(m2.resp_out_val), 80'd0);
        chk("st_cnt_zero", 80'(dut2.r_cnt), 80'd0);
        m2.resp_out_rdy = 1'b0;

        // Spurious response with nothing outstanding.
        m2.resp_in_msg = rs(MEM_RD, 32'h55);
        m2.resp_in_val = 1'b1;
        #1;
        chk("sp_val_same_cycle", 80'(m2.resp_out_val), 80'd0);
        tick();
        m2.resp_in_val = 1'b0;
        #1;
        chk("sp_error_set", 80'(m2.error), 80'd1);
        chk("sp_val_low", 80'(m2.resp_out_val), 80'd0);
        tick();
        chk("sp_error_sticky", 80'(m2.error), 80'd1);
        reset = 1'b1;
        #1;
        chk("sp_error_async_clear", 80'(m2.error), 80'd0);
        tick();
        reset = 1'b0;

        // Reset with two requests outstanding.
        m2.req_in_msg = rq(MEM_RD, 32'h300, 32'd0);
        m2.req_in_val = 1'b1;
        tick();
        tick();
        m2.req_in_val = 1'b0;
        #1;
        chk("mf_blocked_before_reset", 80'(m2.req_in_rdy), 80'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mf_rdy_after_reset", 80'(m2.req_in_rdy), 80'd1);
        chk("mf_val_after_reset", 80'(m2.resp_out_val), 80'd0);
        chk("mf_error_after_reset", 80'(m2.error), 80'd0);
        m2.resp_in_msg = rs(MEM_RD, 32'h77);
        m2.resp_in_val = 1'b1;
        tick();
        m2.resp_in_val = 1'b0;
        #1;
        chk("mf_late_resp_error", 80'(m2.error), 80'd1);
        chk("mf_late_resp_dropped", 80'(m2.resp_out_val), 80'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Depth 3: fill, then push and pop together while full, across the wrap.
        m3.req_out_rdy = 1'b1;
        m3.req_in_msg  = rq(MEM_RD, 32'h400, 32'd0);
        m3.req_in_val  = 1'b1;
        tick();
        tick();
        tick();
        m3.req_in_val = 1'b0;
        #1;
        chk("fl_credit_exhausted", 80'(m3.req_in_rdy), 80'd0);
        m3.resp_in_val = 1'b1;
        m3.resp_in_msg = rs(MEM_RD, 32'hA1);
        tick();
        m3.resp_in_msg = rs(MEM_RD, 32'hA2);
        tick();
        m3.resp_in_msg = rs(MEM_RD, 32'hA3);
        tick();
        m3.resp_in_val = 1'b0;
        #1;
        chk("fl_occ_full", 80'(dut3.u_fifo.r_occ), 80'd3);
        chk("fl_head_a1", 80'(m3.resp_out_msg), 80'(rs(MEM_RD, 32'hA1)));
        m3.resp_in_val  = 1'b1;
        m3.resp_in_msg  = rs(MEM_RD, 32'hA4);
        m3.resp_out_rdy = 1'b1;
        tick();
        m3.resp_in_val = 1'b0;
        #1;
        chk("fl_occ_unchanged", 80'(dut3.u_fifo.r_occ), 80'd3);
        chk("fl_no_error", 80'(m3.error), 80'd0);
        chk("fl_head_a2", 80'(m3.resp_out_msg), 80'(rs(MEM_RD, 32'hA2)));
        tick();
        chk("fl_head_a3", 80'(m3.resp_out_msg), 80'(rs(MEM_RD, 32'hA3)));
        tick();
        chk("fl_head_a4_wrapped", 80'(m3.resp_out_msg), 80'(rs(MEM_RD, 32'hA4)));
        chk("fl_val_a4", 80'(m3.resp_out_val), 80'd1);
        tick();
        chk("fl_drained", 80'(m3.resp_out_val), 80'd0);
        chk("fl_cnt_zero", 80'(dut3.r_cnt), 80'd0);
        m3.resp_out_rdy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
